// File: rtl/ahb_response_mux_ctrl.sv
// AHB slave-to-master response mux with a built-in default slave (decode errors)
// and a wait-state watchdog that aborts stalled transfers with a two-cycle ERROR.
//   state  | meaning
//   S_OK   | forwarding selected slave, or zero-wait OKAY when nothing is selected
//   S_ERR1 | first ERROR cycle (Hready low)
//   S_ERR2 | second ERROR cycle (Hready high, next address phase accepted)
module ahb_response_mux_ctrl #(
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA  = '0
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic [NUM_SLAVES-1:0] slave_select,
    input  logic [1:0]            Htrans,
    input  logic [DATA_WIDTH-1:0] Hrdata_S [NUM_SLAVES],
    input  logic [1:0]            Hresp_S [NUM_SLAVES],
    input  logic [NUM_SLAVES-1:0] Hreadyout_S,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic [1:0]            Hresp,
    output logic                  Hready,
    output logic                  timeout_pulse,
    output logic                  decode_err_pulse
);

    typedef enum logic [1:0] {
        S_OK   = 2'b00,
        S_ERR1 = 2'b01,
        S_ERR2 = 2'b10
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] data_sel_q, data_sel_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  tout_q, tout_d;
    logic                  derr_q, derr_d;

    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [1:0]            sel_resp;
    logic                  sel_ready;

    // Only the transfer/idle distinction of Htrans matters here.
    logic unused_htrans0;
    assign unused_htrans0 = Htrans[0];

    // data_sel_q is always zero or one-hot, so an AND-OR mux is sufficient.
    always_comb begin
        sel_rdata = '0;
        sel_resp  = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (data_sel_q[i]) begin
                sel_rdata = sel_rdata | Hrdata_S[i];
                sel_resp  = sel_resp  | Hresp_S[i];
                sel_ready = sel_ready | Hreadyout_S[i];
            end
        end
    end

    always_comb begin
        Hrdata = DEFAULT_RDATA;
        Hresp  = 2'b00;
        Hready = 1'b1;
        case (state_q)
            S_ERR1: begin
                Hresp  = 2'b01;
                Hready = 1'b0;
            end
            S_ERR2: begin
                Hresp  = 2'b01;
            end
            default: begin
                if (data_sel_q != '0) begin
                    Hrdata = sel_rdata;
                    Hresp  = sel_resp;
                    Hready = sel_ready;
                end
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_sel_d = data_sel_q;
        cnt_d      = cnt_q;
        tout_d     = 1'b0;
        derr_d     = 1'b0;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (!Hready) begin
            // Only reachable in S_OK with the selected slave stalling.
            if (TIMEOUT_CYCLES > 0) begin
                if (cnt_q == CNT_LAST) begin
                    state_d    = S_ERR1;
                    tout_d     = 1'b1;
                    data_sel_d = '0;
                    cnt_d      = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else begin
            state_d = S_OK;
            cnt_d   = '0;
            if (!Htrans[1]) begin
                data_sel_d = '0;
            end else if ($onehot(slave_select)) begin
                data_sel_d = slave_select;
            end else begin
                data_sel_d = '0;
                state_d    = S_ERR1;
                derr_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= S_OK;
            data_sel_q <= '0;
            cnt_q      <= '0;
            tout_q     <= 1'b0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_sel_q <= data_sel_d;
            cnt_q      <= cnt_d;
            tout_q     <= tout_d;
            derr_q     <= derr_d;
        end
    end

    assign timeout_pulse    = tout_q;
    assign decode_err_pulse = derr_q;

endmodule
